// File: rtl/lvd_clkgen_pkg.sv
// Shared definitions for the PLL-lock sequencer and its per-channel enable dividers.
// Latency: n/a (types, constants and an elaboration-time width helper only).
// Backpressure: n/a.
//
// Contents:
//   state_t     sequencer state encoding (also exposed on the debug state port)
//   STATE_W     width of state_t
//   clog2_min1  ceil(log2(n)) clamped to at least 1, for counter widths that may
//               otherwise collapse to zero bits
package lvd_clkgen_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // A counter that has to hold values 0..n-1 needs $clog2(n) bits. For n <= 2
  // that is 0 or 1 bits. A zero-width vector is illegal, so the result is
  // clamped to 1.
  function automatic int clog2_min1(input int n);
    int w;
    w = (n <= 2) ? 1 : $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/clk_en_divider.sv
// One clock-enable channel: emits a 1-cycle strobe every max(div,1) cycles while run is high.
// Latency: first strobe max(div,1) cycles after run rises or after a restart pulse.
// Backpressure: none; free-running strobe with no handshake.
//
// Ports:
//   refclk   in   1      system clock
//   rst_n    in   1      asynchronous active-low reset
//   run      in   1      channel enabled; when low the counter and strobe are held at 0
//   restart  in   1      clears the counter and suppresses the strobe for this cycle
//   div      in   DIV_W  divide ratio; 0 and 1 both give a continuous enable
//   clk_en   out  1      registered enable strobe
module clk_en_divider #(
  parameter int DIV_W = 16
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             clk_en
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_en;
  logic [DIV_W-1:0] w_last;

  // Terminal count is max(div,1)-1. Computing it this way keeps the counter
  // inside DIV_W bits even for div = all-ones, so it never overflows.
  assign w_last = (div == '0) ? '0 : (div - DIV_W'(1));

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else if (!run || restart) begin
      // Restart wins over a coinciding wrap, so no strobe is issued in the
      // load cycle and every channel restarts phase-aligned.
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else if (r_cnt == w_last) begin
      r_cnt <= '0;
      r_en  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
      r_en  <= 1'b0;
    end
  end

  assign clk_en = r_en;

endmodule

// File: rtl/multi_clk_enable_seq.sv
// Filters PLL lock, releases NUM_CH channel resets in a staggered order and drives one
// programmable clock-enable strobe per channel.
// Latency: locked_o rises 3+LOCK_CNT+(NUM_CH-1)*RST_STAGGER edges after pll_locked_i is first sampled high.
// Backpressure: none; outputs are free-running and no handshake exists.
//
// Ports:
//   refclk        in   1              system clock (PLL output domain)
//   rst_n         in   1              asynchronous active-low reset
//   pll_locked_i  in   1              PLL lock flag, asynchronous to refclk
//   div_i         in   NUM_CH*DIV_W   per-channel divide ratio, ch k = [k*DIV_W +: DIV_W]
//   div_load_i    in   1              capture div_i into the shadows and restart all dividers
//   clk_en_o      out  NUM_CH         per-channel 1-cycle enable strobe
//   ch_rst_n_o    out  NUM_CH         per-channel active-low synchronous reset
//   locked_o      out  1              every channel released and running
//   state_o       out  3              sequencer state (debug)
module multi_clk_enable_seq
  import lvd_clkgen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CNT    = 1024,
  parameter int RST_STAGGER = 4
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    pll_locked_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    div_load_i,
  output logic [NUM_CH-1:0]       clk_en_o,
  output logic [NUM_CH-1:0]       ch_rst_n_o,
  output logic                    locked_o,
  output logic [STATE_W-1:0]      state_o
);

  // rel_cnt value at which the last channel is released.
  localparam int REL_LAST = (NUM_CH - 1) * RST_STAGGER;
  localparam int STAB_W   = clog2_min1(LOCK_CNT);
  localparam int REL_W    = clog2_min1(REL_LAST + 1);

  // -------------------------------------------------------------------------
  // Lock synchroniser. The raw PLL flag is used nowhere else.
  // -------------------------------------------------------------------------
  logic r_lock_meta;
  logic r_lock_s;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked_i;
      r_lock_s    <= r_lock_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Divide-ratio shadows. They load in any state, including during lock loss.
  // -------------------------------------------------------------------------
  logic [NUM_CH-1:0][DIV_W-1:0] r_shadow;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_shadow[k] <= DIV_W'(1);
      end
    end else if (div_load_i) begin
      r_shadow <= div_i;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [STAB_W-1:0]   r_stab_cnt;
  logic [STAB_W-1:0]   w_stab_nxt;
  logic [REL_W-1:0]    r_rel_cnt;
  logic [REL_W-1:0]    w_rel_nxt;
  logic [NUM_CH-1:0]   r_ch_rst_n;
  logic [NUM_CH-1:0]   w_ch_rst_n_nxt;
  logic                r_locked;
  logic                w_locked_nxt;
  logic                w_lock_lost;

  // Lock loss only matters once stabilisation has started. Before that,
  // every output is already in its reset value.
  assign w_lock_lost = !r_lock_s &&
                       ((r_state == S_STABLE) || (r_state == S_RELEASE) || (r_state == S_RUN));

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RESET;
      r_stab_cnt <= '0;
      r_rel_cnt  <= '0;
      r_ch_rst_n <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_rel_cnt  <= w_rel_nxt;
      r_ch_rst_n <= w_ch_rst_n_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_stab_nxt     = r_stab_cnt;
    w_rel_nxt      = r_rel_cnt;
    w_ch_rst_n_nxt = r_ch_rst_n;
    w_locked_nxt   = r_locked;

    if (w_lock_lost) begin
      w_state_nxt    = S_WAIT_LOCK;
      w_stab_nxt     = '0;
      w_rel_nxt      = '0;
      w_ch_rst_n_nxt = '0;
      w_locked_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_RESET: begin
          w_state_nxt = S_WAIT_LOCK;
        end

        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nxt = S_STABLE;
            w_stab_nxt  = '0;
          end
        end

        S_STABLE: begin
          if (r_stab_cnt == STAB_W'(LOCK_CNT - 1)) begin
            // Channel 0 releases on the same edge that rel_cnt starts at 0.
            w_rel_nxt         = '0;
            w_ch_rst_n_nxt[0] = 1'b1;
            if (REL_LAST == 0) begin
              // A single channel means there is nothing to stagger.
              w_state_nxt  = S_RUN;
              w_locked_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RELEASE;
            end
          end else begin
            w_stab_nxt = r_stab_cnt + STAB_W'(1);
          end
        end

        S_RELEASE: begin
          w_rel_nxt = r_rel_cnt + REL_W'(1);
          // Each channel's reset lifts on the edge where the count reaches its
          // slot. Bits already set stay set.
          for (int k = 0; k < NUM_CH; k++) begin
            if (w_rel_nxt == REL_W'(k * RST_STAGGER)) begin
              w_ch_rst_n_nxt[k] = 1'b1;
            end
          end
          if (w_rel_nxt == REL_W'(REL_LAST)) begin
            w_state_nxt  = S_RUN;
            w_locked_nxt = 1'b1;
          end
        end

        S_RUN: begin
          w_state_nxt = S_RUN;
        end

        default: begin
          w_state_nxt    = S_RESET;
          w_stab_nxt     = '0;
          w_rel_nxt      = '0;
          w_ch_rst_n_nxt = '0;
          w_locked_nxt   = 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel dividers
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_run;

    // The divider counts only while the channel reset is lifted both now and
    // after this edge. On the release edge it therefore stays at 0, so the
    // first strobe lands max(div,1) cycles later. On a lock-loss edge the
    // counter clears together with the reset.
    assign w_run = r_ch_rst_n[g] & w_ch_rst_n_nxt[g];

    clk_en_divider #(
      .DIV_W (DIV_W)
    ) u_div (
      .refclk  (refclk),
      .rst_n   (rst_n),
      .run     (w_run),
      .restart (div_load_i),
      .div     (r_shadow[g]),
      .clk_en  (clk_en_o[g])
    );
  end

  assign ch_rst_n_o = r_ch_rst_n;
  assign locked_o   = r_locked;
  assign state_o    = r_state;

endmodule
